// File: rtl/rom_1kx8.sv
// rom_1kx8: 1024 x 8 synchronous ROM with a registered read port.
// Each word is its low address byte plus a fixed per-bank offset of 37,
// so the contents are built from a 2-bit bank select and an adder
// rather than from a stored table.
module rom_1kx8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] address,
  output logic [7:0] data
);

  logic [7:0] w_bank_off;
  logic [7:0] w_rom;
  logic [7:0] r_data;

  // Bank offset is 37 * address[9:8]; all four values fit in 8 bits.
  always_comb begin
    w_bank_off = 8'd0;
    case (address[9:8])
      2'd0:    w_bank_off = 8'd0;
      2'd1:    w_bank_off = 8'd37;
      2'd2:    w_bank_off = 8'd74;
      2'd3:    w_bank_off = 8'd111;
      default: w_bank_off = 8'd0;
    endcase
  end

  // The 8-bit add wraps modulo 256, which is exactly the content rule.
  assign w_rom = address[7:0] + w_bank_off;

  // Output register: reset wins over the read on the same edge.
  always_ff @(posedge clk) begin
    if (reset) r_data <= 8'h00;
    else       r_data <= w_rom;
  end

  assign data = r_data;

endmodule

// File: tb/tb_rom_1kx8.sv
// tb_rom_1kx8: directed bench for rom_1kx8. A reference model computes each
// word from the content formula with integer arithmetic; a compare process
// checks every edge against it, and directed steps pin literal values.
module tb_rom_1kx8;

  logic       clk;
  logic       reset;
  logic [9:0] address;
  logic [7:0] data;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b1;
  logic [7:0] cmp_exp;

  rom_1kx8 dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data    (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference content: word value from the formula, computed with plain ints.
  function automatic logic [7:0] model(input int a);
    int v;
    v = ((a % 256) + 37 * (a / 256)) % 256;
    return v[7:0];
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: data=%h expected=%h (t=%0t)", nm, act, exp, $time);
  endtask

  // Every rising edge: predict the register from the sampled inputs,
  // then check it just after the edge.
  always @(posedge clk) begin
    if (cmp_en) begin
      cmp_exp = reset ? 8'h00 : model(int'(address));
      #1;
      chk("model", data, cmp_exp);
    end
  end

  // Inputs change on the falling edge.
  task automatic drive(input int a, input bit r);
    @(negedge clk);
    address = a[9:0];
    reset   = r;
  endtask

  // Literal expectation just after the next rising edge.
  task automatic lit(input string nm, input logic [7:0] exp);
    @(posedge clk);
    #2;
    chk(nm, data, exp);
  endtask

  initial begin
    reset   = 1'b1;
    address = 10'h3FF;

    // Reset held for two edges with a nonzero-word address.
    lit("reset_e1", 8'h00);
    lit("reset_e2", 8'h00);
    drive(1023, 0);
    lit("post_reset_3ff", 8'h6E);

    // Bank boundaries, one cycle after each address.
    drive(255, 0); lit("a255", 8'hFF);
    drive(256, 0); lit("a256", 8'h25);
    drive(511, 0); lit("a511", 8'h24);
    drive(512, 0); lit("a512", 8'h4A);
    drive(767, 0); lit("a767", 8'h49);
    drive(768, 0); lit("a768", 8'h6F);
    drive(0, 0);   lit("a0",   8'h00);

    // Mid-cycle address change must not reach data before the next edge.
    drive(1, 0);
    lit("lat_a1", 8'h01);
    address = 10'd256;
    #1;
    chk("lat_hold", data, 8'h01);
    lit("lat_a256", 8'h25);

    // One-edge reset mid-stream, then resume on the same address.
    drive(512, 1); lit("mid_reset", 8'h00);
    drive(512, 0); lit("after_reset", 8'h4A);

    // Hold the same address for five cycles.
    drive(768, 0);
    for (int i = 0; i < 5; i++) lit($sformatf("hold%0d", i), 8'h6F);

    // Full sequential sweep; the compare process checks each edge.
    for (int a = 0; a < 1024; a++) drive(a, 0);
    @(posedge clk);
    #3;
    cmp_en = 1'b0;
    #10;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
